seg7_count_display: RTL and testbench
=====================================

// Module: seg7_count_display
// PURPOSE
//   Downstream display stage for the 4-bit up/down counter: shows its value (0..15) as two decimal
//   digits plus a direction glyph ('U' up / 'd' down) on a 3-digit multiplexed 7-segment display.
//   Inputs are snapshotted once per scan frame, so digits never tear mid-frame.
//   The block sits between the counter (count_in, mode_in) and the board segment/anode pins.
// PARAMETERS
//   REFRESH_DIV     100000  clk cycles each digit is lit (must be >= 2)
//   SEG_ACTIVE_LOW  1       1: seg pins drive low = lit; 0: high = lit
//   AN_ACTIVE_LOW   1       1: anode enable drives low; 0: high
// PORTS
//   clk          in   1  system clock, rising edge
//   rst          in   1  synchronous reset, active-high
//   count_in     in   4  counter value, unsigned 0..15
//   mode_in      in   1  counter direction, 1 = up, 0 = down
//   seg          out  7  segments, seg[0]=a .. seg[6]=g, polarity per SEG_ACTIVE_LOW
//   an           out  3  digit enables, an[0]=ones, an[1]=tens, an[2]=direction glyph
//   frame_start  out  1  one-cycle pulse in the cycle the input snapshot is taken
// BEHAVIOUR
//   - Reset: div_cnt=0, digit_sel=0, snap_count=0, snap_mode=0, frame_start=0; seg/an registered to all
//     inactive while rst=1. First cycle after rst falls: an selects digit 0, seg shows '0'.
//   - Prescaler: div_cnt counts 0..REFRESH_DIV-1, wraps to 0; tick = (div_cnt==REFRESH_DIV-1).
//   - Scan FSM digit_sel: ONES(0) -> TENS(1) -> DIR(2) -> ONES, advancing only on tick.
//   - Snapshot: on tick with digit_sel==DIR, snap_count<=count_in, snap_mode<=mode_in, frame_start=1
//     that cycle. Input changes at any other time are ignored until the next frame boundary.
//   - BCD: tens = (snap_count>=10); ones = snap_count - (tens ? 10 : 0); 4-bit math, no overflow.
//   - Glyphs (internal active-high, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//     U=3E d=5E blank=00. DIR digit: snap_mode ? 'U' : 'd'.
//   - Output latency: seg/an are registered; they reflect digit_sel/snapshot with 1-cycle latency.
//     Exactly one an bit is active at any time outside reset; polarity inversion applied last.
//   - Reset mid-scan: next cycle outputs inactive; scan restarts at ONES with snapshot 0.
//   - Counter wrap 15<->0 needs no special handling; shown value follows snapshot only.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: TENS digit shows blank (00) when snap_count<10; its anode still
//   cycles so brightness is uniform. Undefined: TENS digit shows '0' for values 0..9.
// STRUCTURE
//   Package seg7_pkg: glyph constants (digits 0-9, U, d, blank), digit_sel enum
//   {DIG_ONES, DIG_TENS, DIG_DIR}, NUM_DIGITS=3.
//   One combinational sub-module seg7_encode (4-bit digit + glyph select -> 7-bit pattern);
//   prescaler, scan FSM, snapshot and output registers live in the top.
// TESTING  (REFRESH_DIV=4, both polarities 1)
//   1 Reset held 3 cycles -> an=111, seg=1111111, frame_start=0; cycle after release an=110, seg=~3F.
//   2 count_in=13, mode_in=1 held -> after first frame_start: ones an=110 seg=~4F ('3') 4 cycles,
//     tens an=101 seg=~06 ('1') 4 cycles, dir an=011 seg=~3E ('U') 4 cycles; frame_start every 12.
//   3 count_in 13->7, mode_in 1->0 during TENS -> rest of frame still '1'/'U'; next frame '7','0'/blank,'d'.
//   4 count_in=5: macro defined -> tens seg=1111111; undefined -> tens seg=~3F.
//   5 rst pulsed 1 cycle during DIR digit -> next cycle all off; then ONES shows '0', frame_start 12 later.
//   6 count_in=15 then 0 across frames -> '5','1' then '0', tens '0'/blank; no glitch, one-hot an.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph patterns, scan-digit enum and anode helper for the counter display.
package seg7_pkg;

    localparam int NUM_DIGITS = 3;

    typedef enum logic [1:0] {
        DIG_ONES = 2'd0,
        DIG_TENS = 2'd1,
        DIG_DIR  = 2'd2
    } digit_sel_t;

    typedef enum logic [1:0] {
        GLYPH_NUM,
        GLYPH_U,
        GLYPH_D,
        GLYPH_BLANK
    } glyph_kind_t;

    // Active-high patterns, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_U     = 7'h3E;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [NUM_DIGITS-1:0] anode_onehot(input digit_sel_t sel);
        logic [NUM_DIGITS-1:0] onehot;
        onehot = '0;
        case (sel)
            DIG_ONES: onehot = 3'b001;
            DIG_TENS: onehot = 3'b010;
            DIG_DIR:  onehot = 3'b100;
            default:  onehot = 3'b001;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational glyph encoder: decimal digit or direction/blank glyph to active-high segments.
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [3:0]  digit,
    input  glyph_kind_t kind,
    output logic [6:0]  pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (kind)
            GLYPH_NUM: begin
                case (digit)
                    4'd0:    pattern = SEG_0;
                    4'd1:    pattern = SEG_1;
                    4'd2:    pattern = SEG_2;
                    4'd3:    pattern = SEG_3;
                    4'd4:    pattern = SEG_4;
                    4'd5:    pattern = SEG_5;
                    4'd6:    pattern = SEG_6;
                    4'd7:    pattern = SEG_7;
                    4'd8:    pattern = SEG_8;
                    4'd9:    pattern = SEG_9;
                    default: pattern = SEG_BLANK;
                endcase
            end
            GLYPH_U: pattern = SEG_U;
            GLYPH_D: pattern = SEG_D;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_count_display.sv
// Multiplexed 3-digit display of a 4-bit counter (two decimal digits plus U/d glyph).
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens digit for values below 10.
module seg7_count_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV    = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            count_in,
    input  logic                  mode_in,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_start
);

    localparam int DIV_W = $clog2(REFRESH_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    digit_sel_t       digit_sel;
    digit_sel_t       digit_next;
    logic [3:0]       snap_count;
    logic             snap_mode;
    logic             tens;
    logic [3:0]       ones;
    logic [3:0]       enc_digit;
    glyph_kind_t      enc_kind;
    logic [6:0]       enc_pattern;

    assign tick        = (div_cnt == DIV_W'(REFRESH_DIV - 1));
    assign frame_start = tick && (digit_sel == DIG_DIR) && !rst;
    assign tens        = (snap_count >= 4'd10);
    assign ones        = snap_count - (tens ? 4'd10 : 4'd0);

    always_comb begin
        digit_next = digit_sel;
        if (tick) begin
            case (digit_sel)
                DIG_ONES: digit_next = DIG_TENS;
                DIG_TENS: digit_next = DIG_DIR;
                default:  digit_next = DIG_ONES;
            endcase
        end
    end

    always_comb begin
        enc_digit = 4'd0;
        enc_kind  = GLYPH_BLANK;
        case (digit_sel)
            DIG_ONES: begin
                enc_kind  = GLYPH_NUM;
                enc_digit = ones;
            end
            DIG_TENS: begin
                enc_kind  = GLYPH_NUM;
                enc_digit = {3'b000, tens};
`ifdef LEADING_ZERO_BLANK_EN
                if (!tens) begin
                    enc_kind = GLYPH_BLANK;
                end
`endif
            end
            DIG_DIR:  enc_kind = snap_mode ? GLYPH_U : GLYPH_D;
            default:  enc_kind = GLYPH_BLANK;
        endcase
    end

    seg7_encode u_encode (
        .digit   (enc_digit),
        .kind    (enc_kind),
        .pattern (enc_pattern)
    );

    // Snapshot only at the frame boundary so a frame never mixes two counter values
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            digit_sel  <= DIG_ONES;
            snap_count <= 4'd0;
            snap_mode  <= 1'b0;
            seg        <= {7{SEG_ACTIVE_LOW}};
            an         <= {NUM_DIGITS{AN_ACTIVE_LOW}};
        end else begin
            div_cnt   <= tick ? '0 : div_cnt + 1'b1;
            digit_sel <= digit_next;
            if (frame_start) begin
                snap_count <= count_in;
                snap_mode  <= mode_in;
            end
            seg <= enc_pattern ^ {7{SEG_ACTIVE_LOW}};
            an  <= anode_onehot(digit_sel) ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_seg7_count_display.sv
// Directed self-checking bench for seg7_count_display with REFRESH_DIV=4, active-low pins.
module tb_seg7_count_display;

    logic       clk;
    logic       rst;
    logic [3:0] count_in;
    logic       mode_in;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_start;

    int checks = 0;
    int errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] TENS_ZERO = 7'h00;
`else
    localparam logic [6:0] TENS_ZERO = 7'h3F;
`endif

    seg7_count_display #(
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .count_in    (count_in),
        .mode_in     (mode_in),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One 12-cycle scan frame; optionally changes the counter inputs after sample chg_at
    task automatic run_frame(input logic [6:0] g_ones, input logic [6:0] g_tens, input logic [6:0] g_dir,
                             input int n, input int chg_at, input logic [3:0] nc, input logic nm,
                             input string tag);
        logic [2:0] exp_an;
        logic [6:0] exp_glyph;
        for (int i = 0; i < n; i++) begin
            tick();
            case (i / 4)
                0:       begin exp_an = 3'b110; exp_glyph = g_ones; end
                1:       begin exp_an = 3'b101; exp_glyph = g_tens; end
                default: begin exp_an = 3'b011; exp_glyph = g_dir;  end
            endcase
            check_output($sformatf("%s_an_%0d", tag, i), {5'd0, an}, {5'd0, exp_an});
            check_output($sformatf("%s_seg_%0d", tag, i), {1'b0, seg}, {1'b0, ~exp_glyph});
            check_output($sformatf("%s_fs_%0d", tag, i), {7'd0, frame_start}, {7'd0, (i == 10)});
            if (i == chg_at) begin
                count_in = nc;
                mode_in  = nm;
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        count_in = 4'd13;
        mode_in  = 1'b1;

        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("reset_an", {5'd0, an}, 8'h07);
            check_output("reset_seg", {1'b0, seg}, 8'h7F);
            check_output("reset_fs", {7'd0, frame_start}, 8'h00);
        end
        rst = 1'b0;

        run_frame(7'h3F, TENS_ZERO, 7'h5E, 12, -1, 4'd0, 1'b0, "f0_boot");
        run_frame(7'h4F, 7'h06, 7'h3E, 12, 5, 4'd7, 1'b0, "f1_13up");
        run_frame(7'h07, TENS_ZERO, 7'h5E, 12, 0, 4'd5, 1'b1, "f2_7down");
        run_frame(7'h6D, TENS_ZERO, 7'h3E, 12, 0, 4'd15, 1'b1, "f3_5up");
        run_frame(7'h6D, 7'h06, 7'h3E, 12, 0, 4'd0, 1'b1, "f4_15up");
        run_frame(7'h3F, TENS_ZERO, 7'h3E, 12, -1, 4'd0, 1'b1, "f5_0up");

        run_frame(7'h3F, TENS_ZERO, 7'h3E, 9, -1, 4'd0, 1'b1, "f6_pre_rst");
        rst = 1'b1;
        tick();
        check_output("midrst_an", {5'd0, an}, 8'h07);
        check_output("midrst_seg", {1'b0, seg}, 8'h7F);
        check_output("midrst_fs", {7'd0, frame_start}, 8'h00);
        rst = 1'b0;
        run_frame(7'h3F, TENS_ZERO, 7'h5E, 12, -1, 4'd0, 1'b1, "f7_after_rst");
        run_frame(7'h3F, TENS_ZERO, 7'h3E, 12, -1, 4'd0, 1'b1, "f8_0up");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
